// File: rtl/gf180mcu_osu_sc_12t_clkgate_ctrl.sv
// ---------------------------------------------------------------------------
// gf180mcu_osu_sc_12t_clkgate_ctrl
//
// Sequencing controller for the clock-gating tree. It owns the enable pins of
// NREQ gated clock branches (ICG + clkinv/clkbuf) and turns them on and off
// for level-sensitive requesters. Turn-ons are serialized by a round-robin
// arbiter with a minimum spacing between grants, which limits supply di/dt.
// Each branch waits SETTLE cycles after enable before acknowledging, and it
// waits HOLD idle cycles after its request drops before shutting down.
//
// Parameters:
//   NREQ   number of gated branches            (1..16)
//   SETTLE cycles from EN rise to ACK rise     (0..15)
//   HOLD   idle cycles before EN falls         (0..255)
//   GAP    minimum cycles between turn-on grants (1..15)
//
// Ports:
//   CLK   in   free-running controller clock, rising edge
//   RN    in   asynchronous active-low reset
//   TE    in   scan/test enable, forces every EN high
//   REQ   in   [NREQ] per-branch clock request (level, CLK-synchronous)
//   EN    out  [NREQ] per-branch gate enable to the ICG
//   ACK   out  [NREQ] per-branch clock-valid acknowledge
//   BUSY  out  any branch waiting for a grant or settling
// ---------------------------------------------------------------------------
module gf180mcu_osu_sc_12t_clkgate_ctrl #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned HOLD   = 8,
  parameter int unsigned GAP    = 1
) (
  input  logic            CLK,
  input  logic            RN,
  input  logic            TE,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] EN,
  output logic [NREQ-1:0] ACK,
  output logic            BUSY
);

  localparam int unsigned CMAX = (SETTLE > HOLD) ? SETTLE : HOLD;
  localparam int unsigned CW   = (CMAX > 0) ? $clog2(CMAX + 1) : 1;
  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned GW   = 4;

  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
  localparam logic [CW-1:0] HOLD_C   = CW'(HOLD);
  localparam logic [GW-1:0] GAP_C    = GW'(GAP - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_WAIT,
    ST_SETTLE,
    ST_ON,
    ST_HOLD
  } state_t;

  state_t          state_q [NREQ];
  state_t          state_d [NREQ];
  logic [CW-1:0]   cnt_q   [NREQ];
  logic [CW-1:0]   cnt_d   [NREQ];

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic [NREQ-1:0] en_q, en_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] grant;
  logic            grant_any;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   scan_idx;

  // A branch is eligible only while it still requests; a withdrawn request
  // leaves WAIT without consuming an arbiter slot.
  always_comb begin
    cand = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand[i] = (state_q[i] == ST_WAIT) && REQ[i];
    end
  end

  // Round-robin scan starting at the pointer; first eligible branch wins.
  // Nothing is granted while the spacing counter is still running.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = PW'((32'(ptr_q) + k) % NREQ);
      if (!grant_any && (gap_q == '0) && cand[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Pointer and grant-spacing counter.
  always_comb begin
    ptr_d = ptr_q;
    gap_d = gap_q;
    if (grant_any) begin
      ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      gap_d = GAP_C;
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end
  end

  // Per-branch next state and counter.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        ST_OFF: begin
          if (REQ[i]) begin
            state_d[i] = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!REQ[i]) begin
            state_d[i] = ST_OFF;
          end else if (grant[i]) begin
            // A grant implies REQ is high, so a zero settle goes straight ON.
            if (SETTLE == 0) begin
              state_d[i] = ST_ON;
            end else begin
              state_d[i] = ST_SETTLE;
              cnt_d[i]   = SETTLE_C;
            end
          end
        end
        ST_SETTLE: begin
          // A request drop does not abort settling; it only picks the exit.
          if (cnt_q[i] <= CW'(1)) begin
            if (REQ[i]) begin
              state_d[i] = ST_ON;
            end else if (HOLD == 0) begin
              state_d[i] = ST_OFF;
            end else begin
              state_d[i] = ST_HOLD;
              cnt_d[i]   = HOLD_C;
            end
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        ST_ON: begin
          if (!REQ[i]) begin
            if (HOLD == 0) begin
              state_d[i] = ST_OFF;
            end else begin
              state_d[i] = ST_HOLD;
              cnt_d[i]   = HOLD_C;
            end
          end
        end
        ST_HOLD: begin
          // Clock is still running, so a returning request needs no grant.
          if (REQ[i]) begin
            state_d[i] = ST_ON;
          end else if (cnt_q[i] <= CW'(1)) begin
            state_d[i] = ST_OFF;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        default: begin
          state_d[i] = ST_OFF;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so EN/ACK/BUSY
  // change on the same edge as the state they describe and never glitch.
  always_comb begin
    en_d   = '0;
    ack_d  = '0;
    busy_d = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      en_d[i]  = (state_d[i] == ST_SETTLE) || (state_d[i] == ST_ON) ||
                 (state_d[i] == ST_HOLD);
      ack_d[i] = (state_d[i] == ST_ON);
      if ((state_d[i] == ST_WAIT) || (state_d[i] == ST_SETTLE)) begin
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
      ptr_q  <= '0;
      gap_q  <= '0;
      en_q   <= '0;
      ack_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      ptr_q  <= ptr_d;
      gap_q  <= gap_d;
      en_q   <= en_d;
      ack_q  <= ack_d;
      busy_q <= busy_d;
    end
  end

  // TE is the only combinational path to an output; it bypasses the flops so
  // scan can open every gate regardless of controller state or reset.
  assign EN   = en_q | {NREQ{TE}};
  assign ACK  = ack_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_clkgate_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for gf180mcu_osu_sc_12t_clkgate_ctrl.
// dut_a: NREQ=4 SETTLE=2 HOLD=8 GAP=1. dut_b: same but GAP=3.
// Each table row drives REQ/TE for 'reps' edges; the expected outputs after
// every edge are hand-derived constants pushed to a scoreboard queue at drive
// time and popped for comparison #1 after the edge.
// ---------------------------------------------------------------------------
module tb_gf180mcu_osu_sc_12t_clkgate_ctrl;

  logic       CLK = 1'b0;
  logic       RN;
  logic       TE;
  logic [3:0] req_a, req_b;
  logic [3:0] en_a, ack_a, en_b, ack_b;
  logic       busy_a, busy_b;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 CLK = ~CLK;

  gf180mcu_osu_sc_12t_clkgate_ctrl #(
    .NREQ(4), .SETTLE(2), .HOLD(8), .GAP(1)
  ) dut_a (
    .CLK(CLK), .RN(RN), .TE(TE), .REQ(req_a),
    .EN(en_a), .ACK(ack_a), .BUSY(busy_a)
  );

  gf180mcu_osu_sc_12t_clkgate_ctrl #(
    .NREQ(4), .SETTLE(2), .HOLD(8), .GAP(3)
  ) dut_b (
    .CLK(CLK), .RN(RN), .TE(TE), .REQ(req_b),
    .EN(en_b), .ACK(ack_b), .BUSY(busy_b)
  );

  typedef struct {
    bit          sel;   // 0: dut_a, 1: dut_b
    logic [3:0]  req;
    logic        te;
    int unsigned reps;
    logic [3:0]  en;
    logic [3:0]  ack;
    logic        busy;
  } vec_t;

  typedef struct {
    bit         sel;
    logic [3:0] en;
    logic [3:0] ack;
    logic       busy;
    int         row;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  function automatic void add(input bit sel, input logic [3:0] req, input logic te,
                              input int unsigned reps, input logic [3:0] en,
                              input logic [3:0] ack, input logic busy);
    vec_t v;
    v.sel = sel; v.req = req; v.te = te; v.reps = reps;
    v.en = en; v.ack = ack; v.busy = busy;
    vecs.push_back(v);
  endfunction

  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r < hi; r++) begin
      for (int unsigned k = 0; k < vecs[r].reps; k++) begin
        exp_t e;
        if (vecs[r].sel) req_b = vecs[r].req;
        else             req_a = vecs[r].req;
        TE = vecs[r].te;
        e.sel = vecs[r].sel; e.en = vecs[r].en; e.ack = vecs[r].ack;
        e.busy = vecs[r].busy; e.row = r;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        if (e.sel) begin
          check($sformatf("row%0d.%0d EN_b", e.row, k),   en_b,            e.en);
          check($sformatf("row%0d.%0d ACK_b", e.row, k),  ack_b,           e.ack);
          check($sformatf("row%0d.%0d BUSY_b", e.row, k), {3'b000, busy_b}, {3'b000, e.busy});
        end else begin
          check($sformatf("row%0d.%0d EN_a", e.row, k),   en_a,            e.en);
          check($sformatf("row%0d.%0d ACK_a", e.row, k),  ack_a,           e.ack);
          check($sformatf("row%0d.%0d BUSY_a", e.row, k), {3'b000, busy_a}, {3'b000, e.busy});
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_a;

    // ---- dut_a table (GAP=1) ----
    // Power-up with all requests held: grants 0,1,2,3 on consecutive edges.
    add(0, 4'hF, 0, 1, 4'h0, 4'h0, 1);
    add(0, 4'hF, 0, 1, 4'h1, 4'h0, 1);
    add(0, 4'hF, 0, 1, 4'h3, 4'h0, 1);
    add(0, 4'hF, 0, 1, 4'h7, 4'h1, 1);
    add(0, 4'hF, 0, 1, 4'hF, 4'h3, 1);
    add(0, 4'hF, 0, 1, 4'hF, 4'h7, 1);
    add(0, 4'hF, 0, 1, 4'hF, 4'hF, 0);
    add(0, 4'hF, 0, 3, 4'hF, 4'hF, 0);
    // All drop; REQ[1] returns after 3 idle cycles, others time out.
    add(0, 4'h0, 0, 3, 4'hF, 4'h0, 0);
    add(0, 4'h2, 0, 1, 4'hF, 4'h2, 0);
    add(0, 4'h2, 0, 4, 4'hF, 4'h2, 0);
    add(0, 4'h2, 0, 1, 4'h2, 4'h2, 0);
    add(0, 4'h2, 0, 2, 4'h2, 4'h2, 0);
    // Pointer still 0 (HOLD->ON took no slot): grant 0 before 2.
    add(0, 4'h7, 0, 1, 4'h2, 4'h2, 1);
    add(0, 4'h7, 0, 1, 4'h3, 4'h2, 1);
    add(0, 4'h7, 0, 1, 4'h7, 4'h2, 1);
    add(0, 4'h7, 0, 1, 4'h7, 4'h3, 1);
    add(0, 4'h7, 0, 1, 4'h7, 4'h7, 0);
    // Drop all: EN falls 8 edges later; TE forces EN while off.
    add(0, 4'h0, 0, 8, 4'h7, 4'h0, 0);
    add(0, 4'h0, 0, 1, 4'h0, 4'h0, 0);
    add(0, 4'h0, 1, 2, 4'hF, 4'h0, 0);
    // REQ[2] high 10 cycles (pointer 3 wraps to 2), then low.
    add(0, 4'h4, 0, 1, 4'h0, 4'h0, 1);
    add(0, 4'h4, 0, 2, 4'h4, 4'h0, 1);
    add(0, 4'h4, 0, 7, 4'h4, 4'h4, 0);
    add(0, 4'h0, 0, 8, 4'h4, 4'h0, 0);
    add(0, 4'h0, 0, 2, 4'h0, 4'h0, 0);
    // Pointer 3: grant order 3,0,1,2.
    add(0, 4'hF, 0, 1, 4'h0, 4'h0, 1);
    add(0, 4'hF, 0, 1, 4'h8, 4'h0, 1);
    add(0, 4'hF, 0, 1, 4'h9, 4'h0, 1);
    add(0, 4'hF, 0, 1, 4'hB, 4'h8, 1);
    add(0, 4'hF, 0, 1, 4'hF, 4'h9, 1);
    add(0, 4'hF, 0, 1, 4'hF, 4'hB, 1);
    add(0, 4'hF, 0, 2, 4'hF, 4'hF, 0);
    n_a = vecs.size();

    // ---- dut_b table (GAP=3) ----
    // Grant branch 1 so the pointer becomes 2, then let it time out.
    add(1, 4'h2, 0, 1, 4'h0, 4'h0, 1);
    add(1, 4'h2, 0, 2, 4'h2, 4'h0, 1);
    add(1, 4'h2, 0, 1, 4'h2, 4'h2, 0);
    add(1, 4'h0, 0, 8, 4'h2, 4'h0, 0);
    add(1, 4'h0, 0, 1, 4'h0, 4'h0, 0);
    // REQ[3] and REQ[0] together: 3 first, 0 three edges later;
    // one-cycle REQ[1] pulse inside the spacing window never gets enabled.
    add(1, 4'h9, 0, 1, 4'h0, 4'h0, 1);
    add(1, 4'h9, 0, 2, 4'h8, 4'h0, 1);
    add(1, 4'h9, 0, 1, 4'h8, 4'h8, 1);
    add(1, 4'h9, 0, 1, 4'h9, 4'h8, 1);
    add(1, 4'hB, 0, 1, 4'h9, 4'h8, 1);
    add(1, 4'h9, 0, 1, 4'h9, 4'h9, 0);
    add(1, 4'h9, 0, 2, 4'h9, 4'h9, 0);
    // Pointer 1: branch 1 first, branch 2 after the gap.
    add(1, 4'hF, 0, 1, 4'h9, 4'h9, 1);
    add(1, 4'hF, 0, 2, 4'hB, 4'h9, 1);
    add(1, 4'hF, 0, 1, 4'hB, 4'hB, 1);
    add(1, 4'hF, 0, 2, 4'hF, 4'hB, 1);
    add(1, 4'hF, 0, 1, 4'hF, 4'hF, 0);

    // ---- reset state ----
    RN = 1'b0; TE = 1'b0; req_a = 4'hF; req_b = 4'h0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset EN_a", en_a, 4'h0);
    check("reset ACK_a", ack_a, 4'h0);
    check("reset BUSY_a", {3'b000, busy_a}, 4'h0);
    check("reset EN_b", en_b, 4'h0);
    TE = 1'b1; #1;
    check("reset TE EN_a", en_a, 4'hF);
    TE = 1'b0; #1;
    check("reset TE off EN_a", en_a, 4'h0);
    RN = 1'b1;

    run_rows(0, n_a);

    // ---- async reset with all branches on and TE high ----
    TE = 1'b1; #1;
    check("pre-reset TE EN_a", en_a, 4'hF);
    RN = 1'b0; #1;
    check("async reset ACK_a", ack_a, 4'h0);
    check("async reset EN_a TE", en_a, 4'hF);
    check("async reset BUSY_a", {3'b000, busy_a}, 4'h0);
    TE = 1'b0; #1;
    check("async reset EN_a", en_a, 4'h0);
    req_a = 4'h0;
    @(negedge CLK);
    RN = 1'b1;

    run_rows(n_a, vecs.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
